// File: rtl/video_timing_gen_if.sv
// Signal bundle between the video timing generator, its frame-buffer RAM and the HDMI transmitter.
// master = the timing generator, slave = the surrounding system.
interface video_timing_gen_if #(
  parameter int ADDR_W = 19
);
  logic              EN;
  logic [23:0]       PX;
  logic [1:0]        MODE;
  logic              INV;
  logic [23:0]       BORDER;
  logic [ADDR_W-1:0] PX_ADDR;
  logic              HDMI_CLK;
  logic              DE;
  logic              HSYNC;
  logic              VSYNC;
  logic [7:0]        RED;
  logic [7:0]        GREEN;
  logic [7:0]        BLUE;
  logic              FRAME_START;

  modport master (
    input  EN, PX, MODE, INV, BORDER,
    output PX_ADDR, HDMI_CLK, DE, HSYNC, VSYNC, RED, GREEN, BLUE, FRAME_START
  );

  modport slave (
    output EN, PX, MODE, INV, BORDER,
    input  PX_ADDR, HDMI_CLK, DE, HSYNC, VSYNC, RED, GREEN, BLUE, FRAME_START
  );
endinterface

// File: rtl/video_timing_gen.sv
// Programmable video timing generator: fetches pixels from a frame buffer and aligns
// DE/syncs/colour to the RAM read latency, with border, grey, colour-bar and invert modes.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int ADDR_W   = 19,
  parameter int MEM_LAT  = 1
) (
  input  logic               CLK_PX,
  input  logic               RST_n,
  video_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int BW      = $clog2(BAR_W + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_IMG    = HW'(IMG_W);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_IMG    = VW'(IMG_H);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  // Per-pixel tag carried alongside the RAM read so everything leaves on the same cycle.
  typedef struct packed {
    logic       act;
    logic       img;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [2:0] bar;
  } tag_t;

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     bar_cnt_q, bar_cnt_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [1:0]        mode_q;
  logic              inv_q;
  tag_t              pipe_q [MEM_LAT];
  tag_t              tag_s, tail;
  logic              de_q, hs_q, vs_q, fs_q;
  logic [23:0]       rgb_q, colour_d, bar_rgb, inv_mask;
  logic              line_end, frame_end;

  assign line_end  = (h_q == H_LAST);
  assign frame_end = line_end && (v_q == V_LAST);

  assign tag_s.act = (h_q < H_ACT) && (v_q < V_ACT);
  assign tag_s.img = (h_q < H_IMG) && (v_q < V_IMG);
  assign tag_s.hs  = (h_q >= HS_START) && (h_q < HS_END);
  assign tag_s.vs  = (v_q >= VS_START) && (v_q < VS_END);
  assign tag_s.fs  = (h_q == '0) && (v_q == '0);
  assign tag_s.bar = bar_idx_q;

  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    addr_d    = addr_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (!vif.EN) begin
      h_d       = '0;
      v_d       = '0;
      addr_d    = '0;
      bar_cnt_d = BAR_LAST;
      bar_idx_d = '0;
    end else begin
      if (line_end) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end

      // Running address replaces y*IMG_W+x: it only advances on image pixels.
      if (frame_end)
        addr_d = '0;
      else if (tag_s.img)
        addr_d = addr_q + ADDR_W'(1);

      // Bar width down-counter; the index saturates so a ragged last bar stays black.
      if (line_end) begin
        bar_cnt_d = BAR_LAST;
        bar_idx_d = '0;
      end else if (h_q < H_ACT) begin
        if (bar_cnt_q == '0) begin
          bar_cnt_d = BAR_LAST;
          if (bar_idx_q != 3'd7)
            bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q - BW'(1);
        end
      end
    end
  end

  assign tail     = pipe_q[MEM_LAT-1];
  assign inv_mask = {24{inv_q}};

  always_comb begin
    case (tail.bar)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    colour_d = '0;
    if (tail.act) begin
      if (mode_q == 2'b10)
        colour_d = bar_rgb ^ inv_mask;
      else if (!tail.img)
        colour_d = vif.BORDER;
      else if (mode_q == 2'b01)
        colour_d = {3{vif.PX[7:0]}} ^ inv_mask;
      else
        colour_d = vif.PX ^ inv_mask;
    end
  end

  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      h_q       <= '0;
      v_q       <= '0;
      addr_q    <= '0;
      bar_cnt_q <= BAR_LAST;
      bar_idx_q <= '0;
      mode_q    <= '0;
      inv_q     <= 1'b0;
      for (int i = 0; i < MEM_LAT; i++)
        pipe_q[i] <= '0;
      de_q      <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      fs_q      <= 1'b0;
      rgb_q     <= '0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      addr_q    <= addr_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      // Latched here, well ahead of pixel (0,0) reaching the colour stage.
      if (vif.EN && tag_s.fs) begin
        mode_q <= vif.MODE;
        inv_q  <= vif.INV;
      end
      if (!vif.EN) begin
        for (int i = 0; i < MEM_LAT; i++)
          pipe_q[i] <= '0;
        de_q  <= 1'b0;
        hs_q  <= ~HS_POL;
        vs_q  <= ~VS_POL;
        fs_q  <= 1'b0;
        rgb_q <= '0;
      end else begin
        pipe_q[0] <= tag_s;
        for (int i = 1; i < MEM_LAT; i++)
          pipe_q[i] <= pipe_q[i-1];
        de_q  <= tail.act;
        hs_q  <= tail.hs ? HS_POL : ~HS_POL;
        vs_q  <= tail.vs ? VS_POL : ~VS_POL;
        fs_q  <= tail.fs;
        rgb_q <= colour_d;
      end
    end
  end

  assign vif.PX_ADDR     = addr_q;
  assign vif.HDMI_CLK    = CLK_PX;
  assign vif.DE          = de_q;
  assign vif.HSYNC       = hs_q;
  assign vif.VSYNC       = vs_q;
  assign vif.FRAME_START = fs_q;
  assign {vif.RED, vif.GREEN, vif.BLUE} = rgb_q;

endmodule
